sample_unpacker: RTL and testbench
==================================

# sample_unpacker

Downstream consumer of the APU sample fetcher. Accepts 64-bit sample chunks over the chunk valid/ack handshake and holds one chunk locally. Emits one 16-bit stereo frame per I2S frame request. Also sequences the fetcher's base address across two CPU-programmed 512-byte buffers (double buffering), pulsing a completion strobe each time a buffer has been fully consumed.

## Interface
Parameters:
- CHUNKS_PER_BUF, 64, chunks per buffer (512 bytes / 8); power of two.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- chunk  in  64  chunk from fetcher
- chunk_valid  in  1  chunk holds valid data
- chunk_ack  out  1  chunk consumed this cycle
- base  out  29  base address offered to fetcher
- base_valid  out  1  base offer pending
- base_ack  in  1  fetcher took base
- buf_base_a  in  29  CPU buffer A address; quasi-static
- buf_base_b  in  29  CPU buffer B address; quasi-static
- buf_sel  out  1  buffer currently requested/streaming (0=A, 1=B)
- buf_done  out  1  one-cycle pulse: last chunk of a buffer accepted
- sample_req  in  1  one-cycle pulse per I2S frame
- sample_l  out  16  left sample, registered
- sample_r  out  16  right sample, registered
- underrun  out  1  sticky: a request found no data
- underrun_clr  in  1  clears underrun

## Operation
- Chunk layout: [15:0] frame0 L, [31:16] frame0 R, [47:32] frame1 L, [63:48] frame1 R.
- Holding register: hold_data (64), hold_valid, frame_idx (1).
- Chunk acceptance:
  - chunk_ack = chunk_valid & ~reset & (~hold_valid | (sample_req & frame_idx==1)). Combinational.
  - On ack: hold_data <= chunk, hold_valid <= 1, frame_idx <= 0.
- sample_req with hold_valid:
  - Output frame[frame_idx].
  - If frame_idx==0: frame_idx <= 1.
  - Else: hold_valid <= 0, unless refilled by the same-cycle ack.
- sample_req with ~hold_valid:
  - sample_l/r <= 0; underrun <= 1.
  - A same-cycle chunk is still accepted.
- underrun_clr clears underrun. A same-cycle set wins.
- Buffer sequencer FSM:
  - BASE_REQ: base_valid=1, base = buf_sel ? buf_base_b : buf_base_a. On base_ack -> STREAM.
  - STREAM: base_valid=0.
- Chunk counter (log2 CHUNKS_PER_BUF bits):
  - Increments on every chunk_ack, in either state.
  - On accepting chunk CHUNKS_PER_BUF-1 (wrap to 0): buf_done pulses.
  - If the wrap occurs in STREAM: buf_sel toggles and FSM -> BASE_REQ.
  - If the wrap occurs in BASE_REQ: buf_done pulses only; buf_sel and state unchanged.
- CPU may rewrite the idle buffer's address any time after its buf_done. The base is sampled combinationally while in BASE_REQ.

## Timing
- Reset values: sample_l/r 0, underrun 0, buf_done 0, buf_sel 0, hold_valid 0, frame_idx 0, counter 0, FSM BASE_REQ.
- base_valid and chunk_ack are forced 0 while reset is high. base_valid rises in the first cycle after reset deasserts.
- Reset mid-operation discards the held chunk and any pending base offer.
- Latencies:
  - sample_req in cycle N -> new sample_l/r visible in cycle N+1.
  - chunk_ack is same-cycle with chunk_valid.
  - Held data is usable by a sample_req in the cycle after acceptance.
- base_valid stays high until base_ack. Dropping to 0 the cycle after base_ack is sampled.
- buf_done is high for exactly the cycle after the wrapping chunk_ack. buf_sel toggles in that same cycle.

## Structure
- Shared apu_pkg:
  - CHUNK_W=64, SAMPLE_W=16, APU_ADDR_W=29.
  - Typedef frame_t {l, r}.
  - Typedef chunk_t as frame_t [1:0].
  - FSM enum {BASE_REQ, STREAM}.
- One sub-module: apu_base_seq, containing the FSM, chunk counter, buf_sel, buf_done and base mux. It takes chunk_ack as input.
- Top level holds the holding register, frame output and underrun logic.

## Test plan
- Reset release, buf_base_a=0x1000, base_ack after 3 cycles -> base=0x1000, base_valid high for exactly 4 cycles, buf_sel=0.
- chunk=0x4444_3333_2222_1111 accepted; two sample_req pulses -> (L,R)=(0x1111,0x2222) then (0x3333,0x4444); second req acks a waiting next chunk in the same cycle.
- sample_req with hold empty -> sample_l/r=0, underrun=1. underrun_clr and a second empty req in the same cycle -> underrun stays 1.
- 64 chunks accepted -> buf_done single pulse after 64th ack, buf_sel=1, base=buf_base_b, base_valid=1. After 64 more -> base returns to buf_base_a.
- Reset asserted with hold_valid=1, frame_idx=1, counter=37 -> next cycle all state at reset values; base_valid reasserts after release; counter restarts at 0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU definitions: bus widths, the frame/chunk layout of packed audio
// data and the buffer sequencer state encoding.
package apu_pkg;

    localparam int CHUNK_W    = 64;
    localparam int SAMPLE_W   = 16;
    localparam int APU_ADDR_W = 29;

    // One stereo frame. The left sample sits in the low half of each 32-bit frame.
    typedef struct packed {
        logic [SAMPLE_W-1:0] r;
        logic [SAMPLE_W-1:0] l;
    } frame_t;

    // Two frames per fetched chunk; element 0 occupies chunk bits [31:0].
    typedef frame_t [1:0] chunk_t;

    // Buffer sequencer: offering a base address, or streaming the current buffer.
    typedef enum logic {
        BASE_REQ = 1'b0,
        STREAM   = 1'b1
    } seq_state_t;

    // Picks one frame out of a held chunk.
    function automatic frame_t select_frame(input chunk_t c, input logic idx);
        return c[idx];
    endfunction

endpackage

// File: rtl/apu_base_seq.sv
// Double-buffer address sequencer. Counts accepted chunks, offers the base
// address of the buffer to fetch next, and strobes buf_done whenever a whole
// buffer's worth of chunks has been consumed.
module apu_base_seq
    import apu_pkg::*;
#(
    parameter int CHUNKS_PER_BUF = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  chunk_ack,
    input  logic                  base_ack,
    input  logic [APU_ADDR_W-1:0] buf_base_a,
    input  logic [APU_ADDR_W-1:0] buf_base_b,
    output logic [APU_ADDR_W-1:0] base,
    output logic                  base_valid,
    output logic                  buf_sel,
    output logic                  buf_done
);

    localparam int CNT_W = $clog2(CHUNKS_PER_BUF);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS_PER_BUF - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] chunk_cnt;
    logic             wrap;

    // The chunk being accepted right now is the last one of a buffer.
    assign wrap = chunk_ack && (chunk_cnt == LAST_CHUNK);

    // The offer is live only while requesting; the address is read straight from
    // the CPU registers so a late rewrite of the idle buffer is still picked up.
    assign base_valid = (state == BASE_REQ) && !reset;
    assign base       = buf_sel ? buf_base_b : buf_base_a;

    // Sequencer FSM with chunk counter, buffer select and completion strobe.
    // A wrap while still waiting for base_ack only reports completion: the
    // pending offer already names the next buffer to fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= BASE_REQ;
            chunk_cnt <= '0;
            buf_sel   <= 1'b0;
            buf_done  <= 1'b0;
        end else begin
            buf_done <= wrap;
            if (chunk_ack) begin
                chunk_cnt <= chunk_cnt + 1'b1;
            end
            case (state)
                BASE_REQ: begin
                    if (base_ack) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (wrap) begin
                        buf_sel <= ~buf_sel;
                        state   <= BASE_REQ;
                    end
                end
                default: state <= BASE_REQ;
            endcase
        end
    end

endmodule

// File: rtl/sample_unpacker.sv
// Unpacks 64-bit sample chunks from the fetcher into 16-bit stereo frames, one
// per I2S frame request, and drives the fetcher's double-buffer base sequencing.
module sample_unpacker
    import apu_pkg::*;
#(
    parameter int CHUNKS_PER_BUF = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHUNK_W-1:0]    chunk,
    input  logic                  chunk_valid,
    output logic                  chunk_ack,
    output logic [APU_ADDR_W-1:0] base,
    output logic                  base_valid,
    input  logic                  base_ack,
    input  logic [APU_ADDR_W-1:0] buf_base_a,
    input  logic [APU_ADDR_W-1:0] buf_base_b,
    output logic                  buf_sel,
    output logic                  buf_done,
    input  logic                  sample_req,
    output logic [SAMPLE_W-1:0]   sample_l,
    output logic [SAMPLE_W-1:0]   sample_r,
    output logic                  underrun,
    input  logic                  underrun_clr
);

    chunk_t hold_data;
    logic   hold_valid;
    logic   frame_idx;
    frame_t cur_frame;
    logic   empty_req;

    assign cur_frame = select_frame(hold_data, frame_idx);
    assign empty_req = sample_req && !hold_valid;

    // Take a new chunk when the holder is empty, or when the request in this
    // cycle is draining its second frame so the stream never stalls.
    assign chunk_ack = chunk_valid && !reset &&
                       (!hold_valid || (sample_req && frame_idx));

    // Holding register: advance through the two frames, refill on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            frame_idx  <= 1'b0;
        end else begin
            if (sample_req && hold_valid) begin
                if (!frame_idx) begin
                    frame_idx <= 1'b1;
                end else begin
                    hold_valid <= 1'b0;
                end
            end
            if (chunk_ack) begin
                hold_data  <= chunk;
                hold_valid <= 1'b1;
                frame_idx  <= 1'b0;
            end
        end
    end

    // Registered frame output; a request with nothing held plays silence.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_l <= '0;
            sample_r <= '0;
        end else if (sample_req) begin
            if (hold_valid) begin
                sample_l <= cur_frame.l;
                sample_r <= cur_frame.r;
            end else begin
                sample_l <= '0;
                sample_r <= '0;
            end
        end
    end

    // Sticky underrun flag; a fresh underrun beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (empty_req) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

    apu_base_seq #(
        .CHUNKS_PER_BUF(CHUNKS_PER_BUF)
    ) u_base_seq (
        .clock      (clock),
        .reset      (reset),
        .chunk_ack  (chunk_ack),
        .base_ack   (base_ack),
        .buf_base_a (buf_base_a),
        .buf_base_b (buf_base_b),
        .base       (base),
        .base_valid (base_valid),
        .buf_sel    (buf_sel),
        .buf_done   (buf_done)
    );

endmodule

// File: tb/tb_sample_unpacker.sv
// Testbench for sample_unpacker: directed scenarios followed by randomized
// traffic, all checked against a frame-queue reference model.
module tb_sample_unpacker;

    localparam int N = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] chunk = '0;
    logic        chunk_valid = 1'b0;
    logic        chunk_ack;
    logic [28:0] base;
    logic        base_valid;
    logic        base_ack = 1'b0;
    logic [28:0] buf_base_a = '0;
    logic [28:0] buf_base_b = '0;
    logic        buf_sel;
    logic        buf_done;
    logic        sample_req = 1'b0;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    sample_unpacker #(.CHUNKS_PER_BUF(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .chunk        (chunk),
        .chunk_valid  (chunk_valid),
        .chunk_ack    (chunk_ack),
        .base         (base),
        .base_valid   (base_valid),
        .base_ack     (base_ack),
        .buf_base_a   (buf_base_a),
        .buf_base_b   (buf_base_b),
        .buf_sel      (buf_sel),
        .buf_done     (buf_done),
        .sample_req   (sample_req),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clock = ~clock;

    // Reference model: frames still waiting to be played, plus buffer bookkeeping.
    logic [31:0] fq[$];
    logic [15:0] m_l, m_r;
    logic        m_under, m_done, m_sel, m_pending;
    int          m_count;

    int          compared;
    int          mismatched;
    logic        obs_ack, obs_bv;
    logic [28:0] obs_base;
    int          bv_high;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        fq.delete();
        m_l = '0;
        m_r = '0;
        m_under = 1'b0;
        m_done = 1'b0;
        m_sel = 1'b0;
        m_pending = 1'b1;
        m_count = 0;
    endtask

    // One clock cycle: drive at the falling edge, check combinational outputs,
    // step the model at the rising edge, check registered outputs at the next fall.
    task automatic applyStimulus(input logic rst, input logic cv, input logic [63:0] ck,
                                 input logic sreq, input logic back, input logic uclr);
        logic        exp_ack;
        logic        empty_req;
        logic        was_pending;
        logic        new_pending;
        logic        wrapped;
        logic [31:0] f;
        reset        = rst;
        chunk_valid  = cv;
        chunk        = ck;
        sample_req   = sreq;
        base_ack     = back;
        underrun_clr = uclr;
        #1;
        exp_ack  = cv && !rst && (fq.size() == 0 || (sreq && fq.size() == 1));
        obs_ack  = chunk_ack;
        obs_bv   = base_valid;
        obs_base = base;
        checkOutput("chunk_ack", 64'(chunk_ack), 64'(exp_ack));
        checkOutput("base_valid", 64'(base_valid), 64'(m_pending && !rst));
        if (base_valid) begin
            bv_high++;
            checkOutput("base", 64'(base), 64'(m_sel ? buf_base_b : buf_base_a));
        end
        @(posedge clock);
        if (rst) begin
            modelReset();
        end else begin
            empty_req   = sreq && (fq.size() == 0);
            was_pending = m_pending;
            if (sreq) begin
                if (fq.size() > 0) begin
                    f   = fq.pop_front();
                    m_l = f[15:0];
                    m_r = f[31:16];
                end else begin
                    m_l = '0;
                    m_r = '0;
                end
            end
            if (empty_req) m_under = 1'b1;
            else if (uclr) m_under = 1'b0;
            wrapped = 1'b0;
            if (exp_ack) begin
                fq.delete();
                fq.push_back(ck[31:0]);
                fq.push_back(ck[63:32]);
                m_count++;
                wrapped = (m_count % N) == 0;
            end
            m_done = wrapped;
            new_pending = was_pending;
            if (was_pending && back) new_pending = 1'b0;
            if (wrapped && !was_pending) begin
                m_sel = ~m_sel;
                new_pending = 1'b1;
            end
            m_pending = new_pending;
        end
        @(negedge clock);
        checkOutput("sample_l", 64'(sample_l), 64'(m_l));
        checkOutput("sample_r", 64'(sample_r), 64'(m_r));
        checkOutput("underrun", 64'(underrun), 64'(m_under));
        checkOutput("buf_done", 64'(buf_done), 64'(m_done));
        checkOutput("buf_sel", 64'(buf_sel), 64'(m_sel));
    endtask

    task automatic fillUntil(input int target);
        int guard;
        guard = 0;
        while (m_count < target && guard < 1000) begin
            applyStimulus(1'b0, 1'b1, {$urandom(), $urandom()}, fq.size() > 0, 1'b0, 1'b0);
            guard++;
        end
        checkOutput("fill_reached", 64'(m_count), 64'(target));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        bv_high    = 0;
        buf_base_a = 29'h1000;
        buf_base_b = 29'h2000;
        modelReset();
        @(negedge clock);

        // Reset holds off acceptance and the base offer.
        applyStimulus(1'b1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_ack_low", 64'(obs_ack), 64'(0));
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

        // Base offer after release, taken three cycles later.
        bv_high = 0;
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("bv_rise", 64'(obs_bv), 64'(1));
        checkOutput("base_first", 64'(obs_base), 64'(29'h1000));
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("bv_cycles", 64'(bv_high), 64'(4));
        checkOutput("sel_init", 64'(buf_sel), 64'(0));

        // Frame unpacking and same-cycle refill.
        applyStimulus(1'b0, 1'b1, 64'h4444_3333_2222_1111, 1'b0, 1'b0, 1'b0);
        checkOutput("ack_first", 64'(obs_ack), 64'(1));
        applyStimulus(1'b0, 1'b1, 64'h8888_7777_6666_5555, 1'b1, 1'b0, 1'b0);
        checkOutput("f0_l", 64'(sample_l), 64'(16'h1111));
        checkOutput("f0_r", 64'(sample_r), 64'(16'h2222));
        applyStimulus(1'b0, 1'b1, 64'h8888_7777_6666_5555, 1'b1, 1'b0, 1'b0);
        checkOutput("ack_refill", 64'(obs_ack), 64'(1));
        checkOutput("f1_l", 64'(sample_l), 64'(16'h3333));
        checkOutput("f1_r", 64'(sample_r), 64'(16'h4444));
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("f3_r", 64'(sample_r), 64'(16'h8888));

        // Underrun: empty request, then set-beats-clear, then clear.
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("ur_l_zero", 64'(sample_l), 64'(0));
        checkOutput("ur_set", 64'(underrun), 64'(1));
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("ur_set_wins", 64'(underrun), 64'(1));
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("ur_clr", 64'(underrun), 64'(0));

        // First buffer completes while streaming: switch to B.
        fillUntil(N);
        checkOutput("done_pulse_a", 64'(buf_done), 64'(1));
        checkOutput("sel_b", 64'(buf_sel), 64'(1));
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("done_single", 64'(buf_done), 64'(0));
        checkOutput("bv_b", 64'(obs_bv), 64'(1));
        checkOutput("base_b", 64'(obs_base), 64'(29'h2000));
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

        // Second buffer completes: back to A.
        fillUntil(2 * N);
        checkOutput("done_pulse_b", 64'(buf_done), 64'(1));
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("base_a_again", 64'(obs_base), 64'(29'h1000));
        checkOutput("sel_a_again", 64'(buf_sel), 64'(0));
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

        // Reset mid-buffer with the second frame of a chunk still held.
        fillUntil(2 * N + 37);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_rst_l", 64'(sample_l), 64'(0));
        checkOutput("mid_rst_sel", 64'(buf_sel), 64'(0));
        applyStimulus(1'b0, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_ack", 64'(obs_ack), 64'(1));
        checkOutput("post_rst_bv", 64'(obs_bv), 64'(1));
        fillUntil(N);
        checkOutput("done_in_req", 64'(buf_done), 64'(1));
        checkOutput("sel_no_toggle", 64'(buf_sel), 64'(0));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 250) begin
                buf_base_a = 29'($urandom());
                buf_base_b = 29'($urandom());
            end
            applyStimulus(1'($urandom_range(0, 499) == 0),
                          1'($urandom_range(0, 9) < 7),
                          {$urandom(), $urandom()},
                          1'($urandom_range(0, 9) < 3),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
